// File: rtl/wb_wide_sram_port.sv
// Wishbone slave that exposes one 64-bit lane of a wide single-port SRAM row per access.
// Reads pull the whole row into a one-row line buffer so later reads of the same row hit.
module wb_wide_sram_port #(
   parameter int MEM_ADDR_BITS    = 10,
   parameter int MEM_DATA_BITS    = 512,
   parameter int WB_DAT_BITS      = 64,
   parameter int WB_SEL_BITS      = WB_DAT_BITS / 8,
   parameter int LANE_BITS        = $clog2(MEM_DATA_BITS / WB_DAT_BITS),
   parameter int WB_ADR_BITS      = MEM_ADDR_BITS + LANE_BITS,
   parameter int MEM_READ_LATENCY = 1,
   parameter int BUF_ENABLE       = 1
) (
   input  logic                       s_wb_clk_i,
   input  logic                       s_wb_rst_i,
   input  logic [WB_ADR_BITS-1:0]     s_wb_adr_i,
   input  logic [WB_DAT_BITS-1:0]     s_wb_dat_i,
   output logic [WB_DAT_BITS-1:0]     s_wb_dat_o,
   input  logic                       s_wb_we_i,
   input  logic [WB_SEL_BITS-1:0]     s_wb_sel_i,
   input  logic                       s_wb_stb_i,
   output logic                       s_wb_ack_o,
   output logic                       m_mem_en,
   output logic [MEM_DATA_BITS/8-1:0] m_mem_we,
   output logic [MEM_ADDR_BITS-1:0]   m_mem_addr,
   output logic [MEM_DATA_BITS-1:0]   m_mem_din,
   input  logic [MEM_DATA_BITS-1:0]   m_mem_dout
);
   localparam int LANES        = MEM_DATA_BITS / WB_DAT_BITS;
   localparam int MEM_SEL_BITS = MEM_DATA_BITS / 8;

   typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_ACK} state_t;

   state_t                   state_reg, state_next;
   logic [1:0]               cnt_reg, cnt_next;
   logic [WB_ADR_BITS-1:0]   adr_reg, adr_next;
   logic [MEM_DATA_BITS-1:0] buf_reg, buf_next;
   logic [MEM_ADDR_BITS-1:0] tag_reg, tag_next;
   logic                     valid_reg, valid_next;
   logic                     ack_reg, ack_next;
   logic [WB_DAT_BITS-1:0]   dat_reg, dat_next;
   logic                     en_reg, en_next;
   logic [MEM_SEL_BITS-1:0]  we_reg, we_next;
   logic [MEM_ADDR_BITS-1:0] addr_reg, addr_next;
   logic [MEM_DATA_BITS-1:0] din_reg, din_next;

   logic [MEM_ADDR_BITS-1:0] req_row, held_row;
   logic [LANE_BITS-1:0]     req_lane, held_lane;
   logic                     tag_hit;
   logic [MEM_SEL_BITS-1:0]  we_mask;
   logic [MEM_DATA_BITS-1:0] din_rep;
   logic [WB_DAT_BITS-1:0]   buf_lane  [LANES];
   logic [WB_DAT_BITS-1:0]   dout_lane [LANES];

   assign req_row   = s_wb_adr_i[WB_ADR_BITS-1:LANE_BITS];
   assign req_lane  = s_wb_adr_i[LANE_BITS-1:0];
   assign held_row  = adr_reg[WB_ADR_BITS-1:LANE_BITS];
   assign held_lane = adr_reg[LANE_BITS-1:0];
   assign tag_hit   = valid_reg && (tag_reg == req_row);

   // Per-lane slicing: byte enables land only in the addressed lane, write data is replicated.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign we_mask[gi*WB_SEL_BITS +: WB_SEL_BITS] =
            (req_lane == LANE_BITS'(gi)) ? s_wb_sel_i : '0;
         assign din_rep[gi*WB_DAT_BITS +: WB_DAT_BITS] = s_wb_dat_i;
         assign buf_lane[gi]  = buf_reg[gi*WB_DAT_BITS +: WB_DAT_BITS];
         assign dout_lane[gi] = m_mem_dout[gi*WB_DAT_BITS +: WB_DAT_BITS];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      adr_next   = adr_reg;
      buf_next   = buf_reg;
      tag_next   = tag_reg;
      valid_next = valid_reg;
      ack_next   = 1'b0;
      dat_next   = dat_reg;
      en_next    = 1'b0;
      we_next    = '0;
      addr_next  = addr_reg;
      din_next   = din_reg;
      case (state_reg)
         IDLE: begin
            if (s_wb_stb_i) begin
               adr_next = s_wb_adr_i;
               if (s_wb_we_i) begin
                  state_next = WRITE;
                  en_next    = 1'b1;
                  we_next    = we_mask;
                  addr_next  = req_row;
                  din_next   = din_rep;
                  ack_next   = 1'b1;
                  // Keep a buffered copy of this row coherent with the SRAM write.
                  if (tag_hit) begin
                     for (int b = 0; b < MEM_SEL_BITS; b++) begin
                        if (we_mask[b]) buf_next[b*8 +: 8] = din_rep[b*8 +: 8];
                     end
                  end
               end else if ((BUF_ENABLE != 0) && tag_hit) begin
                  state_next = RD_ACK;
                  dat_next   = buf_lane[req_lane];
                  ack_next   = 1'b1;
               end else begin
                  state_next = RD_ISSUE;
                  en_next    = 1'b1;
                  addr_next  = req_row;
               end
            end
         end
         RD_ISSUE: begin
            cnt_next   = 2'(MEM_READ_LATENCY - 1);
            state_next = RD_WAIT;
         end
         RD_WAIT: begin
            if (cnt_reg == 2'd0) begin
               buf_next   = m_mem_dout;
               tag_next   = held_row;
               valid_next = (BUF_ENABLE != 0);
               dat_next   = dout_lane[held_lane];
               ack_next   = 1'b1;
               state_next = RD_ACK;
            end else begin
               cnt_next = cnt_reg - 2'd1;
            end
         end
         WRITE, RD_ACK: state_next = IDLE;
         default:       state_next = IDLE;
      endcase
   end

   always_ff @(posedge s_wb_clk_i) begin
      if (s_wb_rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         adr_reg   <= '0;
         tag_reg   <= '0;
         valid_reg <= 1'b0;
         ack_reg   <= 1'b0;
         dat_reg   <= '0;
         en_reg    <= 1'b0;
         we_reg    <= '0;
         addr_reg  <= '0;
         din_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         adr_reg   <= adr_next;
         tag_reg   <= tag_next;
         valid_reg <= valid_next;
         ack_reg   <= ack_next;
         dat_reg   <= dat_next;
         en_reg    <= en_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         din_reg   <= din_next;
      end
   end

   // Buffer contents are qualified by valid_reg, so the data itself needs no reset.
   always_ff @(posedge s_wb_clk_i) begin
      buf_reg <= buf_next;
   end

   assign s_wb_ack_o = ack_reg;
   assign s_wb_dat_o = dat_reg;
   assign m_mem_en   = en_reg;
   assign m_mem_we   = we_reg;
   assign m_mem_addr = addr_reg;
   assign m_mem_din  = din_reg;
endmodule

// File: doc/wb_wide_sram_port.md
# wb_wide_sram_port

Wishbone-slave front end for a wide single-port SRAM. It sits between the AXI4-Lite-to-Wishbone bridge and a 512-bit on-chip memory, and lets the host read and write a 64-bit lane of the wide word at a time:
- Writes go straight through using lane-shifted byte enables.
- Reads fetch the full 512-bit row into a one-row line buffer, so sequential lane reads within a row hit in one cycle.

## Interface
Parameters:
- MEM_ADDR_BITS, 10, SRAM row address width (1024 rows)
- MEM_DATA_BITS, 512, SRAM word width; must be a multiple of WB_DAT_BITS
- WB_DAT_BITS, 64, Wishbone data width
- WB_SEL_BITS, WB_DAT_BITS/8, Wishbone byte-select width
- LANE_BITS, $clog2(MEM_DATA_BITS/WB_DAT_BITS) = 3, lane-index width
- WB_ADR_BITS, MEM_ADDR_BITS+LANE_BITS = 13, Wishbone word-address width
- MEM_READ_LATENCY, 1, SRAM en-to-dout latency in cycles; legal values 1..3
- BUF_ENABLE, 1, 1 = line buffer active; 0 = every read goes to SRAM

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - s_wb_clk_i  input  1  sole clock
  - s_wb_rst_i  input  1  synchronous active-high reset
- Wishbone slave:
  - s_wb_adr_i  input  WB_ADR_BITS  word address; [LANE_BITS-1:0] = lane, upper bits = row
  - s_wb_dat_i  input  WB_DAT_BITS  write data
  - s_wb_dat_o  output  WB_DAT_BITS  read data, registered
  - s_wb_we_i  input  1  1 = write
  - s_wb_sel_i  input  WB_SEL_BITS  byte selects
  - s_wb_stb_i  input  1  request strobe (classic cycle, held until ack)
  - s_wb_ack_o  output  1  single-cycle acknowledge
- SRAM master:
  - m_mem_en  output  1  SRAM access enable
  - m_mem_we  output  MEM_DATA_BITS/8  byte write enables
  - m_mem_addr  output  MEM_ADDR_BITS  row address
  - m_mem_din  output  MEM_DATA_BITS  write data
  - m_mem_dout  input  MEM_DATA_BITS  read data, valid MEM_READ_LATENCY cycles after en with we=0

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_ACK.
- IDLE accepts a request only when s_wb_stb_i=1. A request is never accepted in any other state, and never in the cycle its own ack is driven.
- Write (stb=1, we=1) in IDLE goes to WRITE. Registered outputs for that cycle:
  - m_mem_en=1, m_mem_addr=row.
  - m_mem_din = s_wb_dat_i replicated across all lanes.
  - m_mem_we = s_wb_sel_i shifted by lane×WB_SEL_BITS; all other bits 0.
  - s_wb_ack_o=1.
  - If the line buffer is valid and its tag equals row, the selected bytes of the buffered lane are updated in the same cycle.
  - Next state IDLE.
- Read hit (stb=1, we=0, BUF_ENABLE=1, buffer valid, tag==row) in IDLE goes to RD_ACK: s_wb_dat_o = buffer lane, s_wb_ack_o=1, no SRAM access. Next state IDLE.
- Read miss in IDLE goes to RD_ISSUE: m_mem_en=1, m_mem_we=0, m_mem_addr=row.
- RD_WAIT counts MEM_READ_LATENCY-1 cycles with a down-counter. When dout is valid:
  - buffer ← m_mem_dout, tag ← row, valid ← 1.
  - Go to RD_ACK with s_wb_dat_o = lane of m_mem_dout and ack=1.
- s_wb_sel_i is ignored on reads; the full 64-bit lane is returned.
- s_wb_dat_o holds its value between read acks. Write acks do not change it.
- Write with s_wb_sel_i=0: m_mem_en=1, m_mem_we all 0, ack still issued, buffer unchanged.
- The master dropping stb before ack is a protocol violation. The transaction still completes and ack still pulses.

## Timing
- Reset values:
  - s_wb_ack_o=0, s_wb_dat_o=0.
  - m_mem_en=0, m_mem_we=0, m_mem_addr=0, m_mem_din=0.
  - State IDLE, buffer valid=0.
- Reset asserted mid-transaction: the transaction is abandoned with no ack. Outputs take reset values on the next edge and the buffer is invalidated.
- m_mem_en and m_mem_we are single-cycle pulses.
- Request first seen at edge t:
  - write: en/we and ack at t+1.
  - read hit: ack at t+1.
  - read miss: en at t+1, ack at t+2+MEM_READ_LATENCY (t+3 for latency 1).
- Back-to-back: the earliest next accept is the cycle after ack, so throughput is one write per 2 cycles and one hit per 2 cycles.

## Test plan
- Reset, then idle for 10 cycles -> all outputs 0, no m_mem_en pulse.
- Write adr=13'h0015 (row 2, lane 5), dat=64'h0123_4567_89AB_CDEF, sel=8'hFF -> at t+1:
  - m_mem_addr=2.
  - m_mem_we=64'h0000_FF00_0000_0000, bits [47:40] set.
  - m_mem_din lane 5 = data.
  - ack for 1 cycle.
- Read miss adr=0x0015 with SRAM model latency 1 -> en at t+1, ack at t+3, dat_o=0x0123456789ABCDEF. Then read adr=0x0010 -> hit, ack at t+1, no en.
- Write adr=0x0015, sel=8'h01, dat=…FF while row 2 is buffered, then read 0x0015 -> hit returns 0x0123456789ABCDFF, consistent with SRAM.
- Read row 3 after row 2 is buffered -> miss. Buffer retagged to 3, and a subsequent read of row 2 misses again.
- Reset asserted in RD_WAIT with MEM_READ_LATENCY=3 -> no ack. The next read of the same address misses and returns correct data.
